// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory-bus arbiter: FSM states, owner encodings
// and the default starvation limit for instruction fetch.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } arb_owner_e;

    localparam int STARVE_MAX_DEFAULT = 4;
    localparam int STARVE_W           = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory bus between instruction fetch and data
// memory, one outstanding transaction at a time, with fetch squash support.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    input  logic                if_flush_i,
    output logic [DATA_W-1:0]   if_rdata_o,
    output logic                if_rvalid_o,
    output logic                if_wait_o,
    input  logic                dm_req_i,
    input  logic                dm_we_i,
    input  logic [DATA_W/8-1:0] dm_be_i,
    input  logic [ADDR_W-1:0]   dm_addr_i,
    input  logic [DATA_W-1:0]   dm_wdata_i,
    output logic [DATA_W-1:0]   dm_rdata_o,
    output logic                dm_rvalid_o,
    output logic                dm_wait_o,
    output logic                bus_req_o,
    output logic                bus_we_o,
    output logic [DATA_W/8-1:0] bus_be_o,
    output logic [ADDR_W-1:0]   bus_addr_o,
    output logic [DATA_W-1:0]   bus_wdata_o,
    input  logic                bus_gnt_i,
    input  logic                bus_rvalid_i,
    input  logic [DATA_W-1:0]   bus_rdata_i
);

    localparam logic [STARVE_W-1:0] LP_STARVE_MAX = STARVE_W'(STARVE_MAX);

    arb_state_e            r_state;
    arb_owner_e            r_owner;
    logic                  r_drop;
    logic [STARVE_W-1:0]   r_starve_cnt;
    logic                  r_bus_req;
    logic                  r_bus_we;
    logic [DATA_W/8-1:0]   r_bus_be;
    logic [ADDR_W-1:0]     r_bus_addr;
    logic [DATA_W-1:0]     r_bus_wdata;

    logic w_if_pend;
    logic w_starved;
    logic w_dm_win;
    logic w_if_win;
    logic w_if_flush_owned;

    assign w_if_pend        = if_req_i && !if_flush_i;
    assign w_starved        = w_if_pend && (r_starve_cnt == LP_STARVE_MAX);
    assign w_dm_win         = (r_state == ARB_IDLE) && dm_req_i && !w_starved;
    assign w_if_win         = (r_state == ARB_IDLE) && !w_dm_win && w_if_pend;
    assign w_if_flush_owned = if_flush_i && (r_owner == OWN_IF);

    // A flush landing on the same cycle as the fetch response also kills it.
    assign if_rvalid_o = bus_rvalid_i && (r_state == ARB_RESP) && (r_owner == OWN_IF)
                         && !r_drop && !if_flush_i;
    assign dm_rvalid_o = bus_rvalid_i && (r_state == ARB_RESP) && (r_owner == OWN_DM);
    assign if_rdata_o  = bus_rdata_i;
    assign dm_rdata_o  = bus_rdata_i;
    assign if_wait_o   = if_req_i && !if_flush_i && !if_rvalid_o;
    assign dm_wait_o   = dm_req_i && !dm_rvalid_o;

    assign bus_req_o   = r_bus_req;
    assign bus_we_o    = r_bus_we;
    assign bus_be_o    = r_bus_be;
    assign bus_addr_o  = r_bus_addr;
    assign bus_wdata_o = r_bus_wdata;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= ARB_IDLE;
            r_owner      <= OWN_NONE;
            r_drop       <= 1'b0;
            r_starve_cnt <= '0;
            r_bus_req    <= 1'b0;
            r_bus_we     <= 1'b0;
            r_bus_be     <= '0;
            r_bus_addr   <= '0;
            r_bus_wdata  <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    r_drop <= 1'b0;
                    // Counter tracks consecutive DM wins only while a fetch is waiting.
                    if (!if_req_i || w_if_win) begin
                        r_starve_cnt <= '0;
                    end else if (w_dm_win && w_if_pend && (r_starve_cnt != LP_STARVE_MAX)) begin
                        r_starve_cnt <= r_starve_cnt + 1'b1;
                    end
                    if (w_dm_win) begin
                        r_owner     <= OWN_DM;
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= dm_we_i;
                        r_bus_be    <= dm_be_i;
                        r_bus_addr  <= dm_addr_i;
                        r_bus_wdata <= dm_wdata_i;
                        r_state     <= ARB_REQ;
                    end else if (w_if_win) begin
                        r_owner     <= OWN_IF;
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= 1'b0;
                        r_bus_be    <= '1;
                        r_bus_addr  <= if_addr_i;
                        r_bus_wdata <= '0;
                        r_state     <= ARB_REQ;
                    end
                end
                ARB_REQ: begin
                    if (w_if_flush_owned) begin
                        r_drop <= 1'b1;
                    end
                    if (bus_gnt_i) begin
                        r_bus_req <= 1'b0;
                        r_state   <= ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    if (bus_rvalid_i) begin
                        r_state <= ARB_IDLE;
                        r_owner <= OWN_NONE;
                        r_drop  <= 1'b0;
                    end else if (w_if_flush_owned) begin
                        r_drop <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ARB_IDLE;
                    r_owner   <= OWN_NONE;
                    r_drop    <= 1'b0;
                    r_bus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: latency, priority,
// starvation limit, flush, held request fields and mid-transaction reset.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_flush_i;
    logic [31:0] if_rdata_o;
    logic        if_rvalid_o;
    logic        if_wait_o;
    logic        dm_req_i;
    logic        dm_we_i;
    logic [3:0]  dm_be_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic [31:0] dm_rdata_o;
    logic        dm_rvalid_o;
    logic        dm_wait_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
        .if_rdata_o(if_rdata_o), .if_rvalid_o(if_rvalid_o), .if_wait_o(if_wait_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i),
        .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
        .dm_rdata_o(dm_rdata_o), .dm_rvalid_o(dm_rvalid_o), .dm_wait_o(dm_wait_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Inputs are driven and outputs sampled 1ns after each rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        if_req_i = 0; if_addr_i = 0; if_flush_i = 0;
        dm_req_i = 0; dm_we_i = 0; dm_be_i = 0; dm_addr_i = 0; dm_wdata_i = 0;
        bus_gnt_i = 0; bus_rvalid_i = 0; bus_rdata_i = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n_i = 0;
        #2;
        checks++; if (bus_req_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_bus_req got %b exp 0", bus_req_o); end
        checks++; if ({bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o} !== 69'd0) begin errors++; $display("[TB] FAIL reset_bus_fields got %h exp 0", {bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o}); end
        checks++; if (dut.r_state !== ARB_IDLE) begin errors++; $display("[TB] FAIL reset_state got %0d exp 0", dut.r_state); end
        checks++; if (dut.r_starve_cnt !== 4'd0) begin errors++; $display("[TB] FAIL reset_starve got %0d exp 0", dut.r_starve_cnt); end
        if_req_i = 1; dm_req_i = 1;
        #1;
        checks++; if ({if_wait_o, dm_wait_o} !== 2'b11) begin errors++; $display("[TB] FAIL reset_waits got %b exp 11", {if_wait_o, dm_wait_o}); end
        clear_inputs();
        tick(); tick();
        rst_n_i = 1;
        tick();
    endtask

    task automatic test_if_only();
        if_req_i = 1; if_addr_i = 32'h100; bus_gnt_i = 1;
        checks++; if (bus_req_o !== 1'b0) begin errors++; $display("[TB] FAIL if_c0_bus_req got %b exp 0", bus_req_o); end
        tick();
        checks++; if ({bus_req_o, bus_we_o, bus_be_o, bus_addr_o} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin errors++; $display("[TB] FAIL if_c1_bus got %h exp %h", {bus_req_o, bus_we_o, bus_be_o, bus_addr_o}, {1'b1, 1'b0, 4'hF, 32'h100}); end
        checks++; if (if_wait_o !== 1'b1) begin errors++; $display("[TB] FAIL if_c1_wait got %b exp 1", if_wait_o); end
        tick();
        bus_gnt_i = 0; bus_rvalid_i = 1; bus_rdata_i = 32'h00000013;
        #1;
        checks++; if ({if_rvalid_o, if_rdata_o} !== {1'b1, 32'h13}) begin errors++; $display("[TB] FAIL if_c2_rvalid got %h exp %h", {if_rvalid_o, if_rdata_o}, {1'b1, 32'h13}); end
        checks++; if ({if_wait_o, dm_rvalid_o, bus_req_o} !== 3'b000) begin errors++; $display("[TB] FAIL if_c2_wait got %b exp 000", {if_wait_o, dm_rvalid_o, bus_req_o}); end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_priority();
        if_req_i = 1; if_addr_i = 32'h100;
        dm_req_i = 1; dm_we_i = 1; dm_be_i = 4'b0011; dm_addr_i = 32'h2000; dm_wdata_i = 32'hBEEF;
        bus_gnt_i = 1;
        tick();
        checks++; if ({bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o} !== {1'b1, 1'b1, 4'b0011, 32'h2000, 32'hBEEF}) begin errors++; $display("[TB] FAIL prio_dm_first got %h exp %h", {bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o}, {1'b1, 1'b1, 4'b0011, 32'h2000, 32'hBEEF}); end
        tick();
        bus_rvalid_i = 1;
        #1;
        checks++; if ({dm_rvalid_o, if_rvalid_o, dm_wait_o, if_wait_o} !== 4'b1001) begin errors++; $display("[TB] FAIL prio_dm_ack got %b exp 1001", {dm_rvalid_o, if_rvalid_o, dm_wait_o, if_wait_o}); end
        tick();
        dm_req_i = 0; dm_we_i = 0; bus_rvalid_i = 0;
        checks++; if (dut.r_starve_cnt !== 4'd1) begin errors++; $display("[TB] FAIL prio_starve_one got %0d exp 1", dut.r_starve_cnt); end
        tick();
        checks++; if ({bus_req_o, bus_we_o, bus_be_o, bus_addr_o} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin errors++; $display("[TB] FAIL prio_if_second got %h exp %h", {bus_req_o, bus_we_o, bus_be_o, bus_addr_o}, {1'b1, 1'b0, 4'hF, 32'h100}); end
        tick();
        bus_rvalid_i = 1; bus_rdata_i = 32'h1234;
        #1;
        checks++; if ({if_rvalid_o, if_rdata_o} !== {1'b1, 32'h1234}) begin errors++; $display("[TB] FAIL prio_if_data got %h exp %h", {if_rvalid_o, if_rdata_o}, {1'b1, 32'h1234}); end
        tick();
        clear_inputs();
        checks++; if (dut.r_starve_cnt !== 4'd0) begin errors++; $display("[TB] FAIL prio_starve_clr got %0d exp 0", dut.r_starve_cnt); end
        tick();
    endtask

    task automatic test_starvation();
        logic [31:0] exp_addr;
        if_req_i = 1; if_addr_i = 32'h300;
        dm_req_i = 1; dm_we_i = 0; dm_be_i = 4'hF; dm_addr_i = 32'h4000;
        bus_gnt_i = 1;
        for (int i = 0; i < 5; i++) begin
            exp_addr = (i < 4) ? 32'h4000 : 32'h300;
            tick();
            checks++; if (bus_addr_o !== exp_addr) begin errors++; $display("[TB] FAIL starve_grant%0d got %h exp %h", i, bus_addr_o, exp_addr); end
            tick();
            bus_rvalid_i = 1;
            #1;
            checks++; if ({dm_rvalid_o, if_rvalid_o} !== ((i < 4) ? 2'b10 : 2'b01)) begin errors++; $display("[TB] FAIL starve_route%0d got %b exp %b", i, {dm_rvalid_o, if_rvalid_o}, (i < 4) ? 2'b10 : 2'b01); end
            tick();
            bus_rvalid_i = 0;
        end
        clear_inputs();
        checks++; if (dut.r_starve_cnt !== 4'd0) begin errors++; $display("[TB] FAIL starve_cnt_after got %0d exp 0", dut.r_starve_cnt); end
        tick();
    endtask

    task automatic test_flush();
        if_req_i = 1; if_addr_i = 32'h500; bus_gnt_i = 1;
        tick();
        tick();
        bus_gnt_i = 0; if_flush_i = 1;
        #1;
        checks++; if (if_wait_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_wait got %b exp 0", if_wait_o); end
        tick();
        if_flush_i = 0; if_req_i = 0;
        checks++; if (dut.r_drop !== 1'b1) begin errors++; $display("[TB] FAIL flush_drop_set got %b exp 1", dut.r_drop); end
        bus_rvalid_i = 1; bus_rdata_i = 32'hDEAD;
        #1;
        checks++; if ({if_rvalid_o, dm_rvalid_o} !== 2'b00) begin errors++; $display("[TB] FAIL flush_suppress got %b exp 00", {if_rvalid_o, dm_rvalid_o}); end
        tick();
        bus_rvalid_i = 0;
        checks++; if ({dut.r_state, dut.r_drop, bus_req_o} !== {ARB_IDLE, 1'b0, 1'b0}) begin errors++; $display("[TB] FAIL flush_idle got %b exp 0000", {dut.r_state, dut.r_drop, bus_req_o}); end
        if_req_i = 1; if_addr_i = 32'h600; bus_gnt_i = 1;
        tick();
        tick();
        bus_gnt_i = 0; bus_rvalid_i = 1; if_flush_i = 1;
        #1;
        checks++; if (if_rvalid_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_same_cycle got %b exp 0", if_rvalid_o); end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_gnt_delay();
        dm_req_i = 1; dm_we_i = 1; dm_be_i = 4'hF; dm_addr_i = 32'h6000; dm_wdata_i = 32'hCAFEF00D;
        tick();
        for (int i = 0; i < 4; i++) begin
            dm_addr_i = 32'h6000 + 32'(i + 1) * 32'h10;
            bus_gnt_i = (i == 3);
            #1;
            checks++; if ({bus_req_o, bus_addr_o, bus_wdata_o} !== {1'b1, 32'h6000, 32'hCAFEF00D}) begin errors++; $display("[TB] FAIL hold_cycle%0d got %h exp %h", i, {bus_req_o, bus_addr_o, bus_wdata_o}, {1'b1, 32'h6000, 32'hCAFEF00D}); end
            tick();
        end
        bus_gnt_i = 0; bus_rvalid_i = 1;
        #1;
        checks++; if ({dm_rvalid_o, bus_req_o} !== 2'b10) begin errors++; $display("[TB] FAIL hold_ack got %b exp 10", {dm_rvalid_o, bus_req_o}); end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        dm_req_i = 1; dm_we_i = 0; dm_be_i = 4'hF; dm_addr_i = 32'h7000; bus_gnt_i = 1;
        tick();
        tick();
        checks++; if (dut.r_state !== ARB_RESP) begin errors++; $display("[TB] FAIL rst_mid_in_resp got %0d exp 2", dut.r_state); end
        clear_inputs();
        rst_n_i = 0;
        #1;
        checks++; if ({bus_req_o, bus_addr_o} !== 33'd0) begin errors++; $display("[TB] FAIL rst_mid_async got %h exp 0", {bus_req_o, bus_addr_o}); end
        tick();
        rst_n_i = 1;
        tick();
        bus_rvalid_i = 1; bus_rdata_i = 32'h55AA;
        #1;
        checks++; if ({if_rvalid_o, dm_rvalid_o} !== 2'b00) begin errors++; $display("[TB] FAIL rst_stale_rvalid got %b exp 00", {if_rvalid_o, dm_rvalid_o}); end
        tick();
        checks++; if ({bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o} !== 69'd0) begin errors++; $display("[TB] FAIL rst_stale_bus got %h exp 0", {bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o}); end
        checks++; if (dut.r_state !== ARB_IDLE) begin errors++; $display("[TB] FAIL rst_stale_state got %0d exp 0", dut.r_state); end
        clear_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_if_only();
        test_priority();
        test_starvation();
        test_flush();
        test_gnt_delay();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
